// File: rtl/mem_responder_if.sv
// Memory bus between an initiator (arbiter side) and a word-array responder.
//   memReq/memAddr/memWr/memWData : request, driven by the initiator (master)
//   memRData/memReady/memBusy/memIdle/memErr : response/status, driven by the responder (slave)
interface mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              memReq;
  logic [ADDR_W-1:0] memAddr;
  logic              memWr;
  logic [DATA_W-1:0] memWData;
  logic [DATA_W-1:0] memRData;
  logic              memReady;
  logic              memBusy;
  logic              memIdle;
  logic              memErr;

  modport master (
    output memReq, memAddr, memWr, memWData,
    input  memRData, memReady, memBusy, memIdle, memErr
  );

  modport slave (
    input  memReq, memAddr, memWr, memWData,
    output memRData, memReady, memBusy, memIdle, memErr
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one word read/write at a time into an on-chip
// word array, spends LATENCY cycles busy, then commits and pulses memReady.
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous active-high reset (aborts an in-flight access)
//   bus   : mem_responder_if slave modport (request in, status/data out)
module mem_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        count_reg, count_next;
  logic              accept;
  logic              commit;
  logic              ready;
  logic              busy;
  logic              idle;

  // Request captured at acceptance; later input changes have no effect.
  logic [ADDR_W-1:0] cap_addr_reg;
  logic              cap_wr_reg;
  logic [DATA_W-1:0] cap_wdata_reg;

  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] index;
  logic                  high_bits_set;
  logic                  addr_err;

  assign index = cap_addr_reg[DEPTH_LOG2+1:2];

  // Any address bit above the array's byte range makes the access illegal.
  generate
    if (ADDR_W > DEPTH_LOG2 + 2) begin : g_high
      assign high_bits_set = |cap_addr_reg[ADDR_W-1:DEPTH_LOG2+2];
    end else begin : g_no_high
      assign high_bits_set = 1'b0;
    end
  endgenerate

  assign addr_err = (cap_addr_reg[1:0] != 2'b00) || high_bits_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    accept     = 1'b0;
    commit     = 1'b0;
    ready      = 1'b0;
    busy       = 1'b0;
    idle       = 1'b0;
    case (state_reg)
      IDLE: begin
        idle = 1'b1;
        if (bus.memReq) begin
          accept     = 1'b1;
          count_next = 8'(LATENCY - 1);
          state_next = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (count_reg == 8'd0) begin
          commit     = 1'b1;
          state_next = RESP;
        end else begin
          count_next = count_reg - 8'd1;
        end
      end
      RESP: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_addr_reg  <= bus.memAddr;
      cap_wr_reg    <= bus.memWr;
      cap_wdata_reg <= bus.memWData;
    end
  end

  // Array itself is never cleared; a reset coinciding with commit drops the write.
  always_ff @(posedge clk) begin
    if (commit && cap_wr_reg && !addr_err && !reset) begin
      mem[index] <= cap_wdata_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else if (commit) begin
      err_reg <= addr_err;
      if (!cap_wr_reg) begin
        rdata_reg <= addr_err ? '0 : mem[index];
      end
    end
  end

  assign bus.memRData = rdata_reg;
  assign bus.memErr   = err_reg;
  assign bus.memReady = ready;
  assign bus.memBusy  = busy;
  assign bus.memIdle  = idle;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: three instances (LATENCY 1, 2, 5)
// exercised by directed and randomized accesses against a word-level model.
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  int          sel = 0;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();
  mem_responder_if bus2 ();

  assign bus0.memReq = req && (sel == 0);
  assign bus1.memReq = req && (sel == 1);
  assign bus2.memReq = req && (sel == 2);
  assign bus0.memAddr = addr;  assign bus1.memAddr = addr;  assign bus2.memAddr = addr;
  assign bus0.memWr = wr;      assign bus1.memWr = wr;      assign bus2.memWr = wr;
  assign bus0.memWData = wdata; assign bus1.memWData = wdata; assign bus2.memWData = wdata;

  mem_responder #(.LATENCY(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mem_responder #(.LATENCY(2)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  mem_responder #(.LATENCY(5)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic [31:0] rdata_o;
  logic        ready_o, busy_o, idle_o, err_o;

  always_comb begin
    case (sel)
      0: begin rdata_o = bus0.memRData; ready_o = bus0.memReady; busy_o = bus0.memBusy; idle_o = bus0.memIdle; err_o = bus0.memErr; end
      1: begin rdata_o = bus1.memRData; ready_o = bus1.memReady; busy_o = bus1.memBusy; idle_o = bus1.memIdle; err_o = bus1.memErr; end
      default: begin rdata_o = bus2.memRData; ready_o = bus2.memReady; busy_o = bus2.memBusy; idle_o = bus2.memIdle; err_o = bus2.memErr; end
    endcase
  end

  // Reference model: word array per instance, last read data and error flag.
  int          lat [3] = '{1, 2, 5};
  logic [31:0] ref_mem   [3][1024];
  bit          ref_valid [3][1024];
  logic [31:0] ref_rdata [3];
  logic        ref_err   [3];

  int checks = 0;
  int passed = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd4096);
  endfunction

  // One access. With hold=1 memReq stays high after acceptance with new
  // address/data (ha/hwd) to show that late inputs are ignored.
  task automatic access(input int d, input logic [31:0] a, input bit w, input logic [31:0] wd,
                        input bit hold, input logic [31:0] ha, input logic [31:0] hwd);
    int n;
    int idx;
    sel = d;
    #1;
    n = 0;
    while (!idle_o && n < 50) begin @(posedge clk); #1; n++; end
    check_value("idle_before_req", 32'(idle_o), 32'd1);
    req = 1'b1; addr = a; wr = w; wdata = wd;
    @(posedge clk); #1;
    if (hold) begin
      addr = ha; wdata = hwd;
    end else begin
      req = 1'b0; addr = $urandom; wdata = $urandom; wr = 1'($urandom);
    end
    n = 0;
    while (busy_o && n < 300) begin @(posedge clk); #1; n++; end
    check_value("busy_cycles", 32'(n), 32'(lat[d]));
    check_value("ready_at_end", 32'(ready_o), 32'd1);
    check_value("idle_in_resp", 32'(idle_o), 32'd0);
    idx = int'(a[11:2]);
    if (addr_bad(a)) begin
      ref_err[d] = 1'b1;
      if (!w) ref_rdata[d] = 32'd0;
    end else begin
      ref_err[d] = 1'b0;
      if (w) begin ref_mem[d][idx] = wd; ref_valid[d][idx] = 1'b1; end
      else ref_rdata[d] = ref_mem[d][idx];
    end
    check_value("err", 32'(err_o), 32'(ref_err[d]));
    check_value("rdata", rdata_o, ref_rdata[d]);
    $display("dut%0d %s addr=%h wdata=%h busy=%0d rdata=%h err=%0d", d, w ? "WR" : "RD", a, wd, n, rdata_o, err_o);
    @(posedge clk); #1;
    check_value("ready_one_cycle", 32'(ready_o), 32'd0);
    check_value("idle_after_resp", 32'(idle_o), 32'd1);
  endtask

  task automatic simple(input int d, input logic [31:0] a, input bit w, input logic [31:0] wd);
    access(d, a, w, wd, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    int pulses;
    for (int d = 0; d < 3; d++) begin ref_rdata[d] = 32'd0; ref_err[d] = 1'b0; end
    for (int d = 0; d < 3; d++) for (int i = 0; i < 1024; i++) ref_valid[d][i] = 1'b0;

    // Reset held three cycles
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      sel = d; #1;
      check_value("rst_idle", 32'(idle_o), 32'd1);
      check_value("rst_busy", 32'(busy_o), 32'd0);
      check_value("rst_ready", 32'(ready_o), 32'd0);
      check_value("rst_rdata", rdata_o, 32'd0);
      check_value("rst_err", 32'(err_o), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic write/read, LATENCY=2
    simple(1, 32'h10, 1'b1, 32'hDEADBEEF);
    simple(1, 32'h10, 1'b0, 32'h0);
    // Errors: out of range read, misaligned write (aliases index 4)
    simple(1, 32'h1000, 1'b0, 32'h0);
    simple(1, 32'h12, 1'b1, 32'hBAD0BAD0);
    simple(1, 32'h10, 1'b0, 32'h0);

    // Request held through BUSY/RESP with changed address
    access(1, 32'h40, 1'b1, 32'h11111111, 1'b1, 32'h44, 32'h22222222);
    simple(1, 32'h44, 1'b1, 32'h22222222);
    simple(1, 32'h40, 1'b0, 32'h0);
    simple(1, 32'h44, 1'b0, 32'h0);

    // Reset one cycle into a write: aborted, old value kept
    simple(1, 32'h20, 1'b1, 32'hA5A50020);
    sel = 1;
    req = 1'b1; addr = 32'h20; wr = 1'b1; wdata = 32'h12345678;
    @(posedge clk); #1;
    req = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_value("abort_idle", 32'(idle_o), 32'd1);
    check_value("abort_busy", 32'(busy_o), 32'd0);
    check_value("abort_rdata", rdata_o, 32'd0);
    check_value("abort_err", 32'(err_o), 32'd0);
    for (int d = 0; d < 3; d++) begin ref_rdata[d] = 32'd0; ref_err[d] = 1'b0; end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (ready_o) pulses++;
      @(posedge clk); #1;
    end
    check_value("abort_no_ready", 32'(pulses), 32'd0);
    simple(1, 32'h20, 1'b0, 32'h0);

    // LATENCY=1 back-to-back, then LATENCY=5
    simple(0, 32'h0, 1'b1, 32'hCAFE0000);
    simple(0, 32'h4, 1'b1, 32'hCAFE0004);
    simple(0, 32'h0, 1'b0, 32'h0);
    simple(0, 32'h4, 1'b0, 32'h0);
    simple(2, 32'hFFC, 1'b1, 32'h0F0F0F0F);
    simple(2, 32'hFFC, 1'b0, 32'h0);

    // Randomized accesses across all instances
    for (int t = 0; t < 150; t++) begin
      int d;
      int r;
      logic [31:0] a;
      bit w;
      d = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 9));
      if (r == 0) a = 32'h1000 + ($urandom & 32'h0FFF_FFFC);
      else if (r == 1) a = ($urandom_range(0, 63) << 2) | $urandom_range(1, 3);
      else if (r < 4) a = $urandom_range(0, 1023) << 2;
      else a = $urandom_range(0, 15) << 2;
      w = 1'($urandom);
      if (!w && !addr_bad(a) && !ref_valid[d][a[11:2]]) w = 1'b1;
      simple(d, a, w, $urandom);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
